gmii_tx_framer: RTL and testbench
=================================

Name: gmii_tx_framer

Overview:
Parametrised successor to the minimal GMII TX interface. It takes a byte stream with a valid/ready/last handshake from the client logic and drives the GMII transmit side of the PCS/PMA core on the SGMII user clock. It builds complete 802.3 frames: preamble, SFD, payload, optional zero padding, optional FCS and inter-frame gap. It aborts frames on underrun or oversize and keeps status counters.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes sent before the SFD (range 1..7).
IFG_BYTES, 12, idle cycles enforced after every frame, including aborted frames (minimum 1).
MIN_FRAME, 60, minimum payload-plus-pad byte count before the FCS.
MAX_FRAME, 1514, maximum payload bytes; payloads longer than this are an oversize error.
ADD_PAD, 1, when 1, short frames are padded with 0x00 up to MIN_FRAME.
APPEND_FCS, 1, when 1, a 4-byte CRC32 is appended.
CNT_W, 16, width of the status counters.

Ports:
clock  in  1  GMII/SGMII user clock, 125 MHz.
reset_n  in  1  asynchronous active-low reset.
s_data  in  8  payload byte.
s_valid  in  1  s_data is valid.
s_last  in  1  current byte is the final payload byte.
s_ready  out  1  the framer accepts the byte this cycle.
tx_data  out  8  GMII TXD.
tx_en  out  1  GMII TX_EN.
tx_er  out  1  GMII TX_ER.
frame_done  out  1  one-cycle pulse when a frame ends (good or aborted).
frame_cnt  out  CNT_W  number of good frames sent.
err_cnt  out  CNT_W  number of aborted frames (underrun + oversize).

Behaviour:
- Reset, asynchronous on reset_n low:
  - state = IDLE.
  - tx_data = 0x00, tx_en = 0, tx_er = 0, s_ready = 0, frame_done = 0.
  - frame_cnt = 0, err_cnt = 0.
  - Counters and CRC are cleared.
  - Reset in mid-frame ends the frame immediately: tx_en goes to 0 with no FCS.
- All GMII outputs are registered.
- States: IDLE, PREAMBLE, SFD, DATA, PAD, FCS, DRAIN, IFG.
- IDLE: s_ready = 0. If s_valid = 1 at edge N, tx_en = 1 and tx_data = 0x55 from edge N+1. Go to PREAMBLE.
- PREAMBLE: emits PREAMBLE_LEN bytes of 0x55, then SFD.
- SFD: emits 0xD5. s_ready = 1 during the SFD cycle, so the first payload byte appears on tx_data the cycle after the SFD byte.
- DATA:
  - s_ready = 1. Each handshake (s_valid & s_ready) puts s_data on tx_data at the next edge. The byte count increments and the CRC updates.
  - s_last handshake: go to PAD if ADD_PAD = 1 and the byte count is less than MIN_FRAME. Otherwise go to FCS if APPEND_FCS = 1, else go to IFG.
  - Underrun (s_valid = 0 in DATA): drive tx_en = 1, tx_er = 1, tx_data = 0x00 for one cycle. Increment err_cnt and go to DRAIN.
  - Oversize (handshake of byte MAX_FRAME+1 without s_last): that byte is driven with tx_er = 1. Increment err_cnt. Go to DRAIN, or to IFG if that byte carried s_last.
- PAD: emits 0x00 (included in the CRC) until the byte count equals MIN_FRAME, then goes to FCS or IFG as above. s_ready = 0.
- CRC/FCS:
  - IEEE 802.3 CRC32, reflected polynomial 0xEDB88320, initial value 0xFFFFFFFF.
  - Computed over payload and pad only (not preamble or SFD).
  - Transmitted value is the complement of the register, least-significant byte first, over 4 cycles.
  - s_ready = 0 during FCS.
- DRAIN: tx_en = 0, s_ready = 1. Input bytes are discarded until the s_last handshake, then go to IFG. A frame aborted by underrun must still be completed by the client with s_last.
- IFG: tx_en = 0, tx_er = 0, tx_data = 0x00, s_ready = 0 for IFG_BYTES cycles, then IDLE. s_valid is ignored during IFG.
- frame_done pulses on the cycle tx_en falls, or when DRAIN exits. frame_cnt increments on that edge for good frames only.
- Counters saturate at all-ones and do not wrap.
- tx_er is 0 except in the abort cases above.
- s_ready is asserted only in SFD, DATA and DRAIN.

Test Plan:
- Payload "123456789" (0x31..0x39), ADD_PAD=0, APPEND_FCS=1 -> the bench must see all of the following:
  - 7 × 0x55, then 0xD5, then the 9 payload bytes.
  - FCS bytes 0x26 0x39 0xF4 0xCB.
  - tx_en high for exactly 21 cycles, then 12 idle cycles.
  - frame_cnt = 1.
- 10-byte payload, ADD_PAD=1 -> 10 data bytes, then 50 × 0x00, then 4 FCS bytes. tx_en is high for 72 cycles; the FCS matches a software CRC over all 60 bytes.
- Two back-to-back 64-byte frames with s_valid held high -> exactly IFG_BYTES idle cycles between the two tx_en pulses; frame_cnt = 2.
- s_valid dropped for one cycle after 20 payload bytes -> one cycle with tx_en = 1, tx_er = 1, then tx_en = 0. The remaining bytes are drained until s_last; err_cnt = 1; no FCS is sent.
- 1515-byte payload -> byte 1515 is driven with tx_er = 1 and there is no FCS. err_cnt increments; frame_cnt is unchanged.
- reset_n pulsed low during the DATA state -> on the same edge tx_en = 0, s_ready = 0, counters = 0. The next frame starts cleanly with a full preamble.

Source files
------------

// File: rtl/gmii_tx_framer.sv
// Purpose : GMII transmit framer; turns a valid/ready/last byte stream into 802.3
//           frames (preamble, SFD, payload, zero pad, CRC32 FCS, inter-frame gap).
// Latency : tx_* are registered; an accepted byte appears on tx_data one clock later.
//           s_ready is high only in SFD, DATA and DRAIN. The first byte of a frame is
//           held by the client while the preamble goes out.
//
// Ports:
//   clock, reset_n        - 125 MHz GMII user clock, asynchronous active-low reset
//   s_data/s_valid/s_last - client byte stream; s_ready returns acceptance
//   tx_data/tx_en/tx_er   - GMII transmit outputs (registered)
//   frame_done            - one-cycle pulse when a frame ends, good or aborted
//   frame_cnt/err_cnt     - saturating counts of good and aborted frames
module gmii_tx_framer #(
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_BYTES    = 12,
    parameter int MIN_FRAME    = 60,
    parameter int MAX_FRAME    = 1514,
    parameter int ADD_PAD      = 1,
    parameter int APPEND_FCS   = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       tx_data,
    output logic             tx_en,
    output logic             tx_er,
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    // The byte counter must reach MAX_FRAME+1 (oversize detection) and MIN_FRAME.
    localparam int LEN_MAX = (MAX_FRAME > MIN_FRAME) ? MAX_FRAME : MIN_FRAME;
    localparam int LEN_W   = $clog2(LEN_MAX + 2);
    localparam int IFG_W   = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_DRAIN,
        ST_IFG
    } state_t;

    // Registered state
    state_t           r_state;
    logic [7:0]       r_tx_data;
    logic             r_tx_en;
    logic             r_tx_er;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_frame_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [LEN_W-1:0] r_len;
    logic [2:0]       r_pre_cnt;
    logic [IFG_W-1:0] r_ifg_cnt;
    logic [1:0]       r_fcs_idx;
    logic [31:0]      r_crc;
    logic             r_abort;

    // Next-state values
    state_t           w_nxt_state;
    state_t           w_tail_state;
    logic [7:0]       w_nxt_tx_data;
    logic             w_nxt_tx_en;
    logic             w_nxt_tx_er;
    logic             w_nxt_frame_done;
    logic [LEN_W-1:0] w_nxt_len;
    logic [LEN_W-1:0] w_len_inc;
    logic [2:0]       w_nxt_pre_cnt;
    logic [IFG_W-1:0] w_nxt_ifg_cnt;
    logic [1:0]       w_nxt_fcs_idx;
    logic [31:0]      w_nxt_crc;
    logic             w_nxt_abort;
    logic             w_inc_frame;
    logic             w_inc_err;
    logic             w_ready;

    // Reflected CRC32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign w_ready      = (r_state == ST_SFD) || (r_state == ST_DATA) || (r_state == ST_DRAIN);
    assign w_len_inc    = r_len + 1'b1;
    assign w_tail_state = (APPEND_FCS != 0) ? ST_FCS : ST_IFG;

    always_comb begin
        w_nxt_state      = r_state;
        w_nxt_tx_data    = 8'h00;
        w_nxt_tx_en      = 1'b0;
        w_nxt_tx_er      = 1'b0;
        w_nxt_frame_done = 1'b0;
        w_nxt_len        = r_len;
        w_nxt_pre_cnt    = r_pre_cnt;
        w_nxt_ifg_cnt    = r_ifg_cnt;
        w_nxt_fcs_idx    = r_fcs_idx;
        w_nxt_crc        = r_crc;
        w_nxt_abort      = r_abort;
        w_inc_frame      = 1'b0;
        w_inc_err        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // The pending first byte is not taken here; it waits for SFD.
                if (s_valid) begin
                    w_nxt_tx_en   = 1'b1;
                    w_nxt_tx_data = 8'h55;
                    w_nxt_pre_cnt = 3'd1;
                    w_nxt_len     = '0;
                    w_nxt_crc     = CRC_INIT;
                    w_nxt_fcs_idx = 2'd0;
                    w_nxt_abort   = 1'b0;
                    w_nxt_state   = ST_PREAMBLE;
                end
            end

            ST_PREAMBLE: begin
                // r_pre_cnt counts 0x55 bytes already on the wire.
                w_nxt_tx_en = 1'b1;
                if (r_pre_cnt == 3'(PREAMBLE_LEN)) begin
                    w_nxt_tx_data = 8'hD5;
                    w_nxt_state   = ST_SFD;
                end else begin
                    w_nxt_tx_data = 8'h55;
                    w_nxt_pre_cnt = r_pre_cnt + 3'd1;
                end
            end

            // SFD is on the wire during ST_SFD, so the byte accepted here
            // follows it directly; SFD and DATA share the acceptance logic.
            ST_SFD, ST_DATA: begin
                w_nxt_tx_en = 1'b1;
                if (s_valid) begin
                    w_nxt_tx_data = s_data;
                    w_nxt_len     = w_len_inc;
                    w_nxt_crc     = crc_byte(r_crc, s_data);
                    w_nxt_ifg_cnt = '0;
                    w_nxt_fcs_idx = 2'd0;
                    if (r_len == LEN_W'(MAX_FRAME)) begin
                        // Byte MAX_FRAME+1: flag it on the wire and abort.
                        w_nxt_tx_er = 1'b1;
                        w_inc_err   = 1'b1;
                        w_nxt_abort = 1'b1;
                        w_nxt_state = s_last ? ST_IFG : ST_DRAIN;
                    end else if (s_last) begin
                        if ((ADD_PAD != 0) && (w_len_inc < LEN_W'(MIN_FRAME))) begin
                            w_nxt_state = ST_PAD;
                        end else begin
                            w_nxt_state = w_tail_state;
                        end
                    end else begin
                        w_nxt_state = ST_DATA;
                    end
                end else begin
                    // Underrun: one error symbol, then drop TX_EN.
                    w_nxt_tx_er = 1'b1;
                    w_inc_err   = 1'b1;
                    w_nxt_abort = 1'b1;
                    w_nxt_state = ST_DRAIN;
                end
            end

            ST_PAD: begin
                w_nxt_tx_en   = 1'b1;
                w_nxt_len     = w_len_inc;
                w_nxt_crc     = crc_byte(r_crc, 8'h00);
                w_nxt_ifg_cnt = '0;
                w_nxt_fcs_idx = 2'd0;
                if (w_len_inc == LEN_W'(MIN_FRAME)) begin
                    w_nxt_state = w_tail_state;
                end
            end

            ST_FCS: begin
                // Complemented CRC, least significant byte first; the register
                // is shifted down so the next byte is always in [7:0].
                w_nxt_tx_en   = 1'b1;
                w_nxt_tx_data = ~r_crc[7:0];
                w_nxt_crc     = {8'h00, r_crc[31:8]};
                w_nxt_fcs_idx = r_fcs_idx + 2'd1;
                w_nxt_ifg_cnt = '0;
                if (r_fcs_idx == 2'd3) begin
                    w_nxt_state = ST_IFG;
                end
            end

            ST_DRAIN: begin
                // An aborted frame ends when the client delivers s_last;
                // frame_done marks that point rather than the TX_EN fall.
                if (s_valid && s_last) begin
                    w_nxt_frame_done = 1'b1;
                    w_nxt_ifg_cnt    = '0;
                    w_nxt_state      = ST_IFG;
                end
            end

            ST_IFG: begin
                // TX_EN falls on the first IFG edge when coming from a
                // transmitting state; a drained frame has already pulsed.
                if (r_tx_en) begin
                    w_nxt_frame_done = 1'b1;
                    w_inc_frame      = !r_abort;
                end
                if (r_ifg_cnt == IFG_W'(IFG_BYTES - 1)) begin
                    w_nxt_state = ST_IDLE;
                end else begin
                    w_nxt_ifg_cnt = r_ifg_cnt + 1'b1;
                end
            end

            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_tx_data    <= 8'h00;
            r_tx_en      <= 1'b0;
            r_tx_er      <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_cnt  <= '0;
            r_err_cnt    <= '0;
            r_len        <= '0;
            r_pre_cnt    <= 3'd0;
            r_ifg_cnt    <= '0;
            r_fcs_idx    <= 2'd0;
            r_crc        <= '0;
            r_abort      <= 1'b0;
        end else begin
            r_state      <= w_nxt_state;
            r_tx_data    <= w_nxt_tx_data;
            r_tx_en      <= w_nxt_tx_en;
            r_tx_er      <= w_nxt_tx_er;
            r_frame_done <= w_nxt_frame_done;
            r_len        <= w_nxt_len;
            r_pre_cnt    <= w_nxt_pre_cnt;
            r_ifg_cnt    <= w_nxt_ifg_cnt;
            r_fcs_idx    <= w_nxt_fcs_idx;
            r_crc        <= w_nxt_crc;
            r_abort      <= w_nxt_abort;
            // Status counters stick at all-ones.
            if (w_inc_frame && (r_frame_cnt != '1)) begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_inc_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign s_ready    = w_ready;
    assign tx_data    = r_tx_data;
    assign tx_en      = r_tx_en;
    assign tx_er      = r_tx_er;
    assign frame_done = r_frame_done;
    assign frame_cnt  = r_frame_cnt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: instance u_pad uses default parameters, u_nopad has
// ADD_PAD=0. Inputs change on the falling edge; the wire is logged on the falling
// edge into mon_q and each scenario task checks that log against hand-built values.
module tb_gmii_tx_framer;

    logic clock = 1'b0;
    always #4 clock = ~clock;

    logic reset_n;

    logic [7:0]  a_data, b_data, a_txd, b_txd;
    logic        a_valid, a_last, a_ready, a_en, a_er, a_done;
    logic        b_valid, b_last, b_ready, b_en, b_er, b_done;
    logic [15:0] a_fc, a_ec, b_fc, b_ec;

    gmii_tx_framer u_pad (
        .clock(clock), .reset_n(reset_n),
        .s_data(a_data), .s_valid(a_valid), .s_last(a_last), .s_ready(a_ready),
        .tx_data(a_txd), .tx_en(a_en), .tx_er(a_er), .frame_done(a_done),
        .frame_cnt(a_fc), .err_cnt(a_ec)
    );

    gmii_tx_framer #(.ADD_PAD(0)) u_nopad (
        .clock(clock), .reset_n(reset_n),
        .s_data(b_data), .s_valid(b_valid), .s_last(b_last), .s_ready(b_ready),
        .tx_data(b_txd), .tx_en(b_en), .tx_er(b_er), .frame_done(b_done),
        .frame_cnt(b_fc), .err_cnt(b_ec)
    );

    typedef struct packed {
        logic       done;
        logic       er;
        logic       en;
        logic [7:0] d;
    } smp_t;

    smp_t       mon_q[$];
    logic       mon_on = 1'b0;
    logic       sel_b  = 1'b0;
    logic [8:0] pay[$];     // {last, data}
    int         total  = 0;
    int         bad    = 0;

    always @(negedge clock) begin
        if (mon_on) begin
            if (sel_b) mon_q.push_back({b_done, b_er, b_en, b_txd});
            else       mon_q.push_back({a_done, a_er, a_en, a_txd});
        end
    end

    initial begin
        #4000000;
        $display("FAIL watchdog sim time exceeded");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers (stimulus and log scanning only) ----------------
    task automatic drive(input bit use_b, input bit v, input logic [7:0] d, input bit l);
        if (use_b) begin b_valid = v; b_data = d; b_last = l; end
        else       begin a_valid = v; a_data = d; a_last = l; end
    endtask

    task automatic add_frame(input int n, input logic [7:0] base);
        for (int k = 0; k < n; k++) pay.push_back({(k == n - 1), 8'(base + k)});
    endtask

    // Sends everything in pay with s_valid held high across frame boundaries;
    // optionally drops s_valid for one cycle once drop_at bytes were accepted.
    task automatic send_pay(input bit use_b, input int drop_at);
        int i = 0; int guard = 0; bit rdy; bit dropped = 0;
        while (i < pay.size() && guard < 6000) begin
            @(negedge clock);
            guard++;
            if (!dropped && i == drop_at) begin
                drive(use_b, 1'b0, 8'h00, 1'b0);
                dropped = 1;
                @(posedge clock);
            end else begin
                drive(use_b, 1'b1, pay[i][7:0], pay[i][8]);
                rdy = use_b ? b_ready : a_ready;
                @(posedge clock);
                if (rdy) i++;
            end
        end
        @(negedge clock);
        drive(use_b, 1'b0, 8'h00, 1'b0);
        total++;
        if (i < pay.size()) begin
            bad++;
            $display("FAIL send_timeout accepted=%0d need=%0d", i, pay.size());
        end
        pay.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        mon_q.delete();
    endtask

    function automatic int first_en(input int from);
        for (int i = from; i < mon_q.size(); i++) if (mon_q[i].en === 1'b1) return i;
        return -1;
    endfunction

    function automatic int run_len(input int s);
        int n = 0;
        while (s + n < mon_q.size() && mon_q[s + n].en === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_done();
        int n = 0;
        foreach (mon_q[i]) if (mon_q[i].done === 1'b1) n++;
        return n;
    endfunction

    function automatic int count_er();
        int n = 0;
        foreach (mon_q[i]) if (mon_q[i].er === 1'b1) n++;
        return n;
    endfunction

    // Bitwise reflected CRC32 over the byte list, returns the value to transmit.
    function automatic logic [31:0] sw_fcs(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFFFFFF;
        logic fb;
        foreach (q[i]) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ q[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB88320;
            end
        end
        return ~c;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clock);
        total++; if (a_txd !== 8'h00) begin bad++; $display("FAIL rst_txd got=%h want=00", a_txd); end
        total++; if (a_en !== 1'b0 || a_er !== 1'b0) begin bad++; $display("FAIL rst_en_er got=%b%b want=00", a_en, a_er); end
        total++; if (a_ready !== 1'b0 || a_done !== 1'b0) begin bad++; $display("FAIL rst_ready_done got=%b%b want=00", a_ready, a_done); end
        total++; if (a_fc !== 16'd0 || a_ec !== 16'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d want=0/0", a_fc, a_ec); end
        total++; if (b_en !== 1'b0 || b_fc !== 16'd0) begin bad++; $display("FAIL rst_nopad got en=%b fc=%0d want 0/0", b_en, b_fc); end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        total++; if (a_en !== 1'b0 || a_ready !== 1'b0) begin bad++; $display("FAIL idle_quiet got en=%b rdy=%b want 0/0", a_en, a_ready); end
    endtask

    task automatic test_basic_fcs();
        logic [7:0] want[$];
        int s;
        do_reset();
        sel_b = 1'b1; mon_on = 1'b1;
        add_frame(9, 8'h31);
        send_pay(1, -1);
        repeat (40) @(negedge clock);
        mon_on = 1'b0;
        s = first_en(0);
        total++; if (s < 0) begin bad++; $display("FAIL t1_start no tx_en"); return; end
        for (int k = 0; k < 7; k++) want.push_back(8'h55);
        want.push_back(8'hD5);
        for (int k = 0; k < 9; k++) want.push_back(8'(8'h31 + k));
        want.push_back(8'h26); want.push_back(8'h39); want.push_back(8'hF4); want.push_back(8'hCB);
        for (int k = 0; k < 21; k++) begin
            total++;
            if (mon_q[s + k].d !== want[k]) begin bad++; $display("FAIL t1_byte[%0d] got=%h want=%h", k, mon_q[s + k].d, want[k]); end
        end
        total++; if (run_len(s) != 21) begin bad++; $display("FAIL t1_en_len got=%0d want=21", run_len(s)); end
        for (int k = 21; k < 33; k++) begin
            total++;
            if (mon_q[s + k].en !== 1'b0 || mon_q[s + k].d !== 8'h00) begin bad++; $display("FAIL t1_idle[%0d] got en=%b d=%h want 0/00", k - 21, mon_q[s + k].en, mon_q[s + k].d); end
        end
        total++; if (mon_q[s + 21].done !== 1'b1 || count_done() != 1) begin bad++; $display("FAIL t1_done got=%b n=%0d want 1/1", mon_q[s + 21].done, count_done()); end
        total++; if (count_er() != 0) begin bad++; $display("FAIL t1_er got=%0d want=0", count_er()); end
        total++; if (b_fc !== 16'd1 || b_ec !== 16'd0) begin bad++; $display("FAIL t1_cnt got=%0d/%0d want=1/0", b_fc, b_ec); end
        sel_b = 1'b0;
    endtask

    task automatic test_pad();
        logic [7:0] want[$];
        logic [7:0] body[$];
        logic [31:0] fcs;
        int s;
        do_reset();
        mon_on = 1'b1;
        add_frame(10, 8'h01);
        send_pay(0, -1);
        repeat (90) @(negedge clock);
        mon_on = 1'b0;
        for (int k = 0; k < 10; k++) body.push_back(8'(k + 1));
        for (int k = 0; k < 50; k++) body.push_back(8'h00);
        fcs = sw_fcs(body);
        for (int k = 0; k < 7; k++) want.push_back(8'h55);
        want.push_back(8'hD5);
        foreach (body[i]) want.push_back(body[i]);
        want.push_back(fcs[7:0]); want.push_back(fcs[15:8]); want.push_back(fcs[23:16]); want.push_back(fcs[31:24]);
        s = first_en(0);
        total++; if (s < 0) begin bad++; $display("FAIL pad_start no tx_en"); return; end
        total++; if (run_len(s) != 72) begin bad++; $display("FAIL pad_en_len got=%0d want=72", run_len(s)); end
        for (int k = 0; k < 72; k++) begin
            total++;
            if (mon_q[s + k].d !== want[k]) begin bad++; $display("FAIL pad_byte[%0d] got=%h want=%h", k, mon_q[s + k].d, want[k]); end
        end
        total++; if (a_fc !== 16'd1 || a_ec !== 16'd0) begin bad++; $display("FAIL pad_cnt got=%0d/%0d want=1/0", a_fc, a_ec); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] f1[$];
        logic [7:0] f2[$];
        logic [31:0] w1, w2, g1, g2;
        int s1, s2;
        do_reset();
        mon_on = 1'b1;
        add_frame(64, 8'h00);
        add_frame(64, 8'h80);
        send_pay(0, -1);
        repeat (40) @(negedge clock);
        mon_on = 1'b0;
        for (int k = 0; k < 64; k++) begin f1.push_back(8'(k)); f2.push_back(8'(8'h80 + k)); end
        w1 = sw_fcs(f1); w2 = sw_fcs(f2);
        s1 = first_en(0);
        total++; if (s1 < 0) begin bad++; $display("FAIL b2b_start no tx_en"); return; end
        total++; if (run_len(s1) != 76) begin bad++; $display("FAIL b2b_len1 got=%0d want=76", run_len(s1)); end
        s2 = first_en(s1 + run_len(s1));
        total++; if (s2 - (s1 + run_len(s1)) != 12) begin bad++; $display("FAIL b2b_gap got=%0d want=12", s2 - (s1 + run_len(s1))); end
        if (s2 < 0) return;
        total++; if (run_len(s2) != 76) begin bad++; $display("FAIL b2b_len2 got=%0d want=76", run_len(s2)); end
        g1 = {mon_q[s1 + 75].d, mon_q[s1 + 74].d, mon_q[s1 + 73].d, mon_q[s1 + 72].d};
        g2 = {mon_q[s2 + 75].d, mon_q[s2 + 74].d, mon_q[s2 + 73].d, mon_q[s2 + 72].d};
        total++; if (g1 !== w1) begin bad++; $display("FAIL b2b_fcs1 got=%h want=%h", g1, w1); end
        total++; if (g2 !== w2) begin bad++; $display("FAIL b2b_fcs2 got=%h want=%h", g2, w2); end
        total++; if (mon_q[s2 + 8].d !== 8'h80) begin bad++; $display("FAIL b2b_first2 got=%h want=80", mon_q[s2 + 8].d); end
        total++; if (a_fc !== 16'd2 || count_done() != 2) begin bad++; $display("FAIL b2b_cnt got fc=%0d done=%0d want 2/2", a_fc, count_done()); end
    endtask

    task automatic test_underrun();
        int s;
        do_reset();
        mon_on = 1'b1;
        add_frame(30, 8'h40);
        send_pay(0, 20);
        repeat (30) @(negedge clock);
        mon_on = 1'b0;
        s = first_en(0);
        total++; if (s < 0) begin bad++; $display("FAIL urun_start no tx_en"); return; end
        total++; if (run_len(s) != 29) begin bad++; $display("FAIL urun_en_len got=%0d want=29", run_len(s)); end
        total++; if (mon_q[s + 27].d !== 8'h53 || mon_q[s + 27].er !== 1'b0) begin bad++; $display("FAIL urun_last_good got d=%h er=%b want 53/0", mon_q[s + 27].d, mon_q[s + 27].er); end
        total++; if (mon_q[s + 28].er !== 1'b1 || mon_q[s + 28].d !== 8'h00) begin bad++; $display("FAIL urun_err_sym got er=%b d=%h want 1/00", mon_q[s + 28].er, mon_q[s + 28].d); end
        total++; if (count_er() != 1) begin bad++; $display("FAIL urun_er_count got=%0d want=1", count_er()); end
        total++; if (first_en(s + 29) != -1) begin bad++; $display("FAIL urun_no_fcs tx_en again at %0d want none", first_en(s + 29)); end
        total++; if (a_ec !== 16'd1 || a_fc !== 16'd0) begin bad++; $display("FAIL urun_cnt got err=%0d frm=%0d want 1/0", a_ec, a_fc); end
        total++; if (count_done() != 1) begin bad++; $display("FAIL urun_done got=%0d want=1", count_done()); end
    endtask

    task automatic test_oversize();
        int s;
        do_reset();
        mon_on = 1'b1;
        add_frame(1514, 8'h00);
        send_pay(0, -1);
        repeat (30) @(negedge clock);
        mon_on = 1'b0;
        s = first_en(0);
        total++; if (s < 0 || run_len(s) != 1526) begin bad++; $display("FAIL max_len got=%0d want=1526", (s < 0) ? 0 : run_len(s)); end
        total++; if (count_er() != 0 || a_fc !== 16'd1 || a_ec !== 16'd0) begin bad++; $display("FAIL max_good got er=%0d frm=%0d err=%0d want 0/1/0", count_er(), a_fc, a_ec); end
        mon_q.delete();
        mon_on = 1'b1;
        add_frame(1515, 8'h00);
        send_pay(0, -1);
        repeat (30) @(negedge clock);
        mon_on = 1'b0;
        s = first_en(0);
        total++; if (s < 0) begin bad++; $display("FAIL ovr_start no tx_en"); return; end
        total++; if (run_len(s) != 1523) begin bad++; $display("FAIL ovr_en_len got=%0d want=1523", run_len(s)); end
        total++; if (mon_q[s + 1522].er !== 1'b1 || mon_q[s + 1522].d !== 8'hEA) begin bad++; $display("FAIL ovr_err_byte got er=%b d=%h want 1/ea", mon_q[s + 1522].er, mon_q[s + 1522].d); end
        total++; if (mon_q[s + 1521].er !== 1'b0 || count_er() != 1) begin bad++; $display("FAIL ovr_er_only_last got er1514=%b n=%0d want 0/1", mon_q[s + 1521].er, count_er()); end
        total++; if (first_en(s + 1523) != -1) begin bad++; $display("FAIL ovr_no_fcs tx_en again at %0d want none", first_en(s + 1523)); end
        total++; if (a_ec !== 16'd1 || a_fc !== 16'd1) begin bad++; $display("FAIL ovr_cnt got err=%0d frm=%0d want 1/1", a_ec, a_fc); end
        total++; if (count_done() != 1) begin bad++; $display("FAIL ovr_done got=%0d want=1", count_done()); end
    endtask

    task automatic test_reset_midframe();
        int s;
        do_reset();
        add_frame(60, 8'h10);
        send_pay(0, -1);
        repeat (20) @(negedge clock);
        total++; if (a_fc !== 16'd1) begin bad++; $display("FAIL mid_pre_cnt got=%0d want=1", a_fc); end
        @(negedge clock);
        drive(0, 1'b1, 8'h77, 1'b0);
        repeat (20) @(posedge clock);
        #2;
        total++; if (a_en !== 1'b1 || a_ready !== 1'b1) begin bad++; $display("FAIL mid_in_data got en=%b rdy=%b want 1/1", a_en, a_ready); end
        reset_n = 1'b0;
        #1;
        total++; if (a_en !== 1'b0 || a_er !== 1'b0 || a_txd !== 8'h00) begin bad++; $display("FAIL mid_rst_tx got en=%b er=%b d=%h want 0/0/00", a_en, a_er, a_txd); end
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", a_ready); end
        total++; if (a_fc !== 16'd0 || a_ec !== 16'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d/%0d want=0/0", a_fc, a_ec); end
        drive(0, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        mon_q.delete();
        mon_on = 1'b1;
        add_frame(60, 8'h20);
        send_pay(0, -1);
        repeat (30) @(negedge clock);
        mon_on = 1'b0;
        s = first_en(0);
        total++; if (s < 0) begin bad++; $display("FAIL mid_next_start no tx_en"); return; end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (mon_q[s + k].d !== ((k == 7) ? 8'hD5 : 8'h55)) begin bad++; $display("FAIL mid_next_pre[%0d] got=%h want=%h", k, mon_q[s + k].d, (k == 7) ? 8'hD5 : 8'h55); end
        end
        total++; if (run_len(s) != 72) begin bad++; $display("FAIL mid_next_len got=%0d want=72", run_len(s)); end
        total++; if (a_fc !== 16'd1 || a_ec !== 16'd0) begin bad++; $display("FAIL mid_next_cnt got=%0d/%0d want=1/0", a_fc, a_ec); end
    endtask

    initial begin
        test_reset();
        test_basic_fcs();
        test_pad();
        test_back_to_back();
        test_underrun();
        test_oversize();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
